ysyx_22051145_muldiv_unit: RTL and testbench

//  Execute-side consumer of the decoder's MULDIV info group (RV64M: mul/mulh/mulhsu/mulhu/div/divu/rem/remu).

---
 rtl/ysyx_22051145_muldiv_pkg.sv | 26 ++
 rtl/ysyx_22051145_muldiv_abs.sv | 12 +
 rtl/ysyx_22051145_muldiv_unit.sv | 139 +++++++++++++
 tb/tb_ysyx_22051145_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051145_muldiv_pkg.sv
// Shared constants for the RV64M multiply/divide unit: op bit indices, FSM states, helpers.
package ysyx_22051145_muldiv_pkg;
    localparam int XLEN = 64;

    // Bit positions inside the decoder's one-hot MULDIV info group
    localparam int DECINFO_MULDIV_MUL    = 0;
    localparam int DECINFO_MULDIV_MULH   = 1;
    localparam int DECINFO_MULDIV_MULHSU = 2;
    localparam int DECINFO_MULDIV_MULHU  = 3;
    localparam int DECINFO_MULDIV_DIV    = 4;
    localparam int DECINFO_MULDIV_DIVU   = 5;
    localparam int DECINFO_MULDIV_REM    = 6;
    localparam int DECINFO_MULDIV_REMU   = 7;
    localparam int DECINFO_MULDIV_W      = 8;

    typedef enum logic [1:0] {
        MULDIV_IDLE = 2'd0,
        MULDIV_MUL  = 2'd1,
        MULDIV_DIV  = 2'd2,
        MULDIV_DONE = 2'd3
    } muldiv_state_t;

    function automatic logic is_onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction
endpackage

// File: rtl/ysyx_22051145_muldiv_abs.sv
// Conditional two's-complement negate; used both for operand magnitude and result sign fix-up.
module ysyx_22051145_muldiv_abs
    import ysyx_22051145_muldiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? (~a + W'(1)) : a;
endmodule

// File: rtl/ysyx_22051145_muldiv_unit.sv
// Iterative RV64M unit: radix-2 shift-add multiplier and restoring divider sharing one
// 2*XLEN accumulator, one op in flight, valid/ready on both sides.
module ysyx_22051145_muldiv_unit
    import ysyx_22051145_muldiv_pkg::*;
#(
    parameter int XLEN = ysyx_22051145_muldiv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    muldiv_state_t     state;
    logic [CNT_W-1:0]  counter;
    logic [2*XLEN-1:0] acc;     // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]   opnd;    // MUL: multiplicand; DIV: divisor
    logic              neg_q, neg_r, op_lo, op_rem;

    logic              sgn1, sgn2, s1, s2, onehot, in_is_mul, in_is_div, in_is_rem;
    logic              div_zero, ovf, special;
    logic [XLEN-1:0]   abs1, abs2, special_res;

    assign in_ready  = (state == MULDIV_IDLE) & ~flush;

    assign sgn1      = in_op[DECINFO_MULDIV_MUL] | in_op[DECINFO_MULDIV_MULH] | in_op[DECINFO_MULDIV_MULHSU]
                     | in_op[DECINFO_MULDIV_DIV] | in_op[DECINFO_MULDIV_REM];
    assign sgn2      = in_op[DECINFO_MULDIV_MUL] | in_op[DECINFO_MULDIV_MULH]
                     | in_op[DECINFO_MULDIV_DIV] | in_op[DECINFO_MULDIV_REM];
    assign s1        = sgn1 & in_rs1[XLEN-1];
    assign s2        = sgn2 & in_rs2[XLEN-1];
    assign onehot    = is_onehot8(in_op);
    assign in_is_mul = |in_op[DECINFO_MULDIV_MULHU:DECINFO_MULDIV_MUL];
    assign in_is_div = |in_op[DECINFO_MULDIV_REMU:DECINFO_MULDIV_DIV];
    assign in_is_rem = in_op[DECINFO_MULDIV_REM] | in_op[DECINFO_MULDIV_REMU];
    assign div_zero  = (in_rs2 == '0);
    assign ovf       = (in_op[DECINFO_MULDIV_DIV] | in_op[DECINFO_MULDIV_REM])
                     & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_rs2 == '1);
    assign special   = ~onehot | (in_is_div & (div_zero | ovf));

    always_comb begin
        special_res = '0;
        if (onehot && div_zero)
            special_res = in_is_rem ? in_rs1 : '1;
        else if (onehot && ovf)
            special_res = in_is_rem ? '0 : in_rs1;
    end

    ysyx_22051145_muldiv_abs #(.W(XLEN)) u_abs1 (.a(in_rs1), .neg(s1), .y(abs1));
    ysyx_22051145_muldiv_abs #(.W(XLEN)) u_abs2 (.a(in_rs2), .neg(s2), .y(abs2));

    // One step of each algorithm, evaluated combinationally from the accumulator
    logic [XLEN:0]     sum, shifted, diff;
    logic              ge;
    logic [2*XLEN-1:0] prod_next, prod_fix;
    logic [XLEN-1:0]   rem_next, quot_next, dv_fix_in, dv_fix, mul_res;

    assign sum       = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    assign prod_next = {sum, acc[XLEN-1:1]};
    assign shifted   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign ge        = shifted >= {1'b0, opnd};
    assign diff      = shifted - {1'b0, opnd};
    assign rem_next  = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quot_next = {acc[XLEN-2:0], ge};
    assign dv_fix_in = op_rem ? rem_next : quot_next;

    ysyx_22051145_muldiv_abs #(.W(2*XLEN)) u_abs_prod (.a(prod_next), .neg(neg_q), .y(prod_fix));
    ysyx_22051145_muldiv_abs #(.W(XLEN)) u_abs_dv (.a(dv_fix_in), .neg(op_rem ? neg_r : neg_q), .y(dv_fix));

    assign mul_res = op_lo ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MULDIV_IDLE;
            counter    <= '0;
            acc        <= '0;
            opnd       <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            op_lo      <= 1'b0;
            op_rem     <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_rd     <= '0;
        end else if (flush) begin
            state     <= MULDIV_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                MULDIV_IDLE: if (in_valid) begin
                    counter <= '0;
                    out_rd  <= in_rd;
                    neg_q   <= s1 ^ s2;
                    neg_r   <= s1;
                    op_lo   <= in_op[DECINFO_MULDIV_MUL];
                    op_rem  <= in_is_rem;
                    if (special) begin
                        out_result <= special_res;
                        out_valid  <= 1'b1;
                        state      <= MULDIV_DONE;
                    end else if (in_is_mul) begin
                        opnd  <= abs1;
                        acc   <= {{XLEN{1'b0}}, abs2};
                        state <= MULDIV_MUL;
                    end else begin
                        opnd  <= abs2;
                        acc   <= {{XLEN{1'b0}}, abs1};
                        state <= MULDIV_DIV;
                    end
                end
                MULDIV_MUL, MULDIV_DIV: begin
                    acc <= (state == MULDIV_MUL) ? prod_next : {rem_next, quot_next};
                    if (counter == CNT_W'(XLEN-1)) begin
                        out_result <= (state == MULDIV_MUL) ? mul_res : dv_fix;
                        out_valid  <= 1'b1;
                        state      <= MULDIV_DONE;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                MULDIV_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= MULDIV_IDLE;
                end
                default: state <= MULDIV_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22051145_muldiv_unit.sv
// Directed and randomized checks of the muldiv unit against an arithmetic reference model.
module tb_ysyx_22051145_muldiv_unit;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_op;
    logic [63:0] in_rs1, in_rs2, out_result;
    logic [4:0]  in_rd, out_rd;

    int checks = 0;
    int errors = 0;

    ysyx_22051145_muldiv_unit dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus the RISC-V corner-case rules
    function automatic logic [63:0] model(input int opi, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb, p;
        logic signed [63:0] sa, sb;
        sa = a;
        sb = b;
        case (opi)
            0: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
            1: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; p = ea * eb; return p[127:64]; end
            2: begin ea = {{64{a[63]}}, a}; eb = {64'd0, b}; p = ea * eb; return p[127:64]; end
            3: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4: if (b == 0) return '1; else if (a == MIN && b == '1) return a; else return 64'(sa / sb);
            5: if (b == 0) return '1; else return a / b;
            6: if (b == 0) return a; else if (a == MIN && b == '1) return 64'd0; else return 64'(sa % sb);
            default: if (b == 0) return a; else return a % b;
        endcase
    endfunction

    function automatic bit is_special(input int opi, input logic [63:0] a, input logic [63:0] b);
        return (opi >= 4) && ((b == 0) || ((opi == 4 || opi == 6) && a == MIN && b == '1));
    endfunction

    task automatic start_op(input int opi, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        @(negedge clk);
        chk("in_ready before accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = 8'd1 << opi;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counted in edges after the accept edge, sampled on the falling edge
    task automatic wait_valid(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = k;
                break;
            end
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("out_valid after handshake", 64'(out_valid), 64'd0);
        chk("in_ready after handshake", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input int opi, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd);
        bit seen;
        int lat;
        start_op(opi, a, b, rd);
        wait_valid(seen, lat);
        chk({tag, " valid"}, 64'(seen), 64'd1);
        chk({tag, " latency"}, 64'(lat), is_special(opi, a, b) ? 64'd0 : 64'd64);
        chk({tag, " result"}, out_result, model(opi, a, b));
        chk({tag, " rd"}, 64'(out_rd), 64'(rd));
        handshake();
    endtask

    initial begin
        bit seen;
        int lat, hits, opi, mode;
        logic [63:0] a, b, hold_res;
        logic [4:0] hold_rd;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_result", out_result, 64'd0);
        chk("reset out_rd", 64'(out_rd), 64'd0);
        @(negedge clk) rst = 1'b0;

        run_op("mul 3*-5", 0, 64'd3, -64'sd5, 5'd7);
        chk("mul 3*-5 literal", out_result, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("mulhu max", 3, '1, '1, 5'd1);
        chk("mulhu max literal", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulh -1*-1", 1, '1, '1, 5'd2);
        run_op("mulhsu -1*2", 2, '1, 64'd2, 5'd3);
        chk("mulhsu literal", out_result, '1);
        run_op("divu 100/7", 5, 64'd100, 64'd7, 5'd4);
        chk("divu literal", out_result, 64'd14);
        run_op("remu 100/7", 7, 64'd100, 64'd7, 5'd5);
        chk("remu literal", out_result, 64'd2);
        run_op("div -7/2", 4, -64'sd7, 64'd2, 5'd6);
        chk("div literal", out_result, -64'sd3);
        run_op("rem -7/2", 6, -64'sd7, 64'd2, 5'd8);
        chk("rem literal", out_result, '1);
        run_op("div 7/0", 4, 64'd7, 64'd0, 5'd9);
        run_op("rem 7/0", 6, 64'd7, 64'd0, 5'd10);
        chk("rem 7/0 literal", out_result, 64'd7);
        run_op("div ovf", 4, MIN, '1, 5'd11);
        chk("div ovf literal", out_result, MIN);
        run_op("rem ovf", 6, MIN, '1, 5'd12);
        run_op("divu x/0", 5, 64'h1234, 64'd0, 5'd13);
        run_op("remu x/0", 7, 64'h1234, 64'd0, 5'd14);

        for (int i = 0; i < 24; i++) begin
            opi  = int'($urandom_range(0, 7));
            mode = int'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (mode == 1) b = ($urandom_range(0, 1) != 0) ? 64'($urandom_range(1, 1000))
                                                            : -64'($urandom_range(1, 1000));
            if (mode == 2 && i % 3 == 0) b = 64'd0;
            if (mode == 3 && i % 3 == 0) begin a = MIN; b = '1; end
            run_op("random", opi, a, b, 5'($urandom_range(0, 31)));
        end

        // Backpressure: result parked in DONE while a second request waits
        start_op(0, 64'd12345, 64'd678, 5'd21);
        wait_valid(seen, lat);
        chk("bp valid", 64'(seen), 64'd1);
        hold_res = out_result;
        hold_rd  = out_rd;
        chk("bp result", hold_res, model(0, 64'd12345, 64'd678));
        in_valid = 1'b1; in_op = 8'h20; in_rs1 = 64'd9; in_rs2 = 64'd2; in_rd = 5'd30;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp out_valid held", 64'(out_valid), 64'd1);
            chk("bp result held", out_result, hold_res);
            chk("bp rd held", 64'(out_rd), 64'(hold_rd));
            chk("bp in_ready low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        handshake();
        run_op("after bp", 5, 64'd9, 64'd2, 5'd30);

        // Flush in the middle of a divide, with a competing request on the same cycle
        start_op(4, 64'd1000, 64'd3, 5'd17);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = 8'h01; in_rs1 = 64'd2; in_rs2 = 64'd3; in_rd = 5'd18;
        #1 chk("flush in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        chk("flush out_valid", 64'(out_valid), 64'd0);
        chk("flush idle", 64'(in_ready), 64'd1);
        hits = 0;
        repeat (80) begin @(negedge clk); if (out_valid) hits++; end
        chk("flush no result", 64'(hits), 64'd0);

        // Asynchronous reset mid-multiply
        start_op(3, '1, 64'h55, 5'd25);
        repeat (20) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst in_ready", 64'(in_ready), 64'd1);
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst out_result", out_result, 64'd0);
        chk("arst out_rd", 64'(out_rd), 64'd0);
        @(negedge clk) rst = 1'b0;
        hits = 0;
        repeat (80) begin @(negedge clk); if (out_valid) hits++; end
        chk("arst no result", 64'(hits), 64'd0);
        run_op("after arst", 1, -64'sd9, 64'd4, 5'd26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
